binary_to_gray_conv: RTL and testbench

Registered binary-to-Gray code converter with a parameterised data width and a default of 4 bits. Each accepted binary word is converted with `g = b ^ (b >> 1)` and presented one clock later, qualified by a valid flag. An internal Gray-to-binary round-trip check raises an error flag if the registered code does not decode back to its source. The block sits between counters or address generators and any consumer that needs single-bit-change encoding, such as CDC pointers or encoders.

---
 rtl/gray_pkg.sv | 44 ++++
 rtl/gray_to_binary.sv | 24 ++
 rtl/binary_to_gray_conv.sv | 76 +++++++
 tb/tb_binary_to_gray_conv.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the binary/Gray conversion blocks.
//   DEFAULT_WIDTH : default data width of the converter.
//   bin2gray      : binary -> Gray over the low w bits of a 32-bit word.
//   gray2bin      : Gray -> binary over the low w bits of a 32-bit word.
// Bits at or above w are forced to zero in both results.
// ---------------------------------------------------------------------------
package gray_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // Builds a mask of w ones.
   // A shift by 32 would overflow a 32-bit word, so full width is handled
   // as a special case.
   function automatic logic [31:0] widthMask(input int w);
      logic [31:0] mask;
      if (w >= 32) begin
         mask = 32'hFFFF_FFFF;
      end else begin
         mask = (32'd1 << w) - 32'd1;
      end
      return mask;
   endfunction

   // Each Gray bit is the XOR of two neighbouring binary bits.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int w);
      logic [31:0] inBits;
      inBits = bin & widthMask(w);
      return (inBits ^ (inBits >> 1)) & widthMask(w);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   // Shift-doubling builds that prefix XOR in five passes.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int w);
      logic [31:0] d;
      d = gray & widthMask(w);
      for (int s = 1; s < 32; s = s * 2) begin
         d = d ^ (d >> s);
      end
      return d & widthMask(w);
   endfunction

endpackage

// File: rtl/gray_to_binary.sv
// ---------------------------------------------------------------------------
// gray_to_binary
// Purely combinational Gray-to-binary decoder.
//   WIDTH  : data width in bits (2..32)
//   i_gray : Gray-coded input word
//   o_bin  : decoded binary word
// Bit i of the result is the XOR reduction of Gray bits WIDTH-1 down to i.
// Writing each bit as an independent reduction keeps the network free of
// bit-to-bit feedback within one vector.
// ---------------------------------------------------------------------------
module gray_to_binary
   import gray_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   for (genvar i = 0; i < WIDTH; i++) begin : genBit
      assign o_bin[i] = ^i_gray[WIDTH-1:i];
   end

endmodule

// File: rtl/binary_to_gray_conv.sv
// ---------------------------------------------------------------------------
// binary_to_gray_conv
// Registered binary-to-Gray converter with an internal round-trip check.
//   WIDTH     : data width in bits (2..32)
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   b         : binary input word, sampled when in_valid is high
//   in_valid  : qualifies b on this edge
//   g         : Gray code of the last accepted word
//   out_valid : g was refreshed by the previous edge
//   rt_err    : decode of g differed from its source word (one cycle later)
// ---------------------------------------------------------------------------
module binary_to_gray_conv
   import gray_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] g,
   output logic             out_valid,
   output logic             rt_err
);

   logic [WIDTH-1:0] w_gNext;
   logic [WIDTH-1:0] w_decoded;
   logic             w_mismatch;

   logic [WIDTH-1:0] r_g;
   logic [WIDTH-1:0] r_bQ;
   logic             r_outValid;
   logic             r_rtErr;

   // Combinational encode of the incoming word.
   assign w_gNext = WIDTH'(bin2gray(32'(b), WIDTH));

   // Independent decoder used to confirm the registered code.
   gray_to_binary #(
      .WIDTH (WIDTH)
   ) uDecode (
      .i_gray (r_g),
      .o_bin  (w_decoded)
   );

   assign w_mismatch = r_outValid & (w_decoded != r_bQ);

   // Data path registers load only on accepted words.
   // b is never sampled while in_valid is low, so X there cannot reach g.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_g  <= '0;
         r_bQ <= '0;
      end else if (in_valid) begin
         r_g  <= w_gNext;
         r_bQ <= b;
      end
   end

   // Valid follows in_valid by one edge; the error flag follows valid by one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_rtErr    <= 1'b0;
      end else begin
         r_outValid <= in_valid;
         r_rtErr    <= w_mismatch;
      end
   end

   assign g         = r_g;
   assign out_valid = r_outValid;
   assign rt_err    = r_rtErr;

endmodule

// File: tb/tb_binary_to_gray_conv.sv
// ---------------------------------------------------------------------------
// tb_binary_to_gray_conv
// Directed bench for the converter at WIDTH=4 and WIDTH=8.
// ---------------------------------------------------------------------------
module tb_binary_to_gray_conv;
   import gray_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] b4;
   logic       inValid4;
   logic [3:0] g4;
   logic       outValid4;
   logic       rtErr4;
   logic [7:0] b8;
   logic       inValid8;
   logic [7:0] g8;
   logic       outValid8;
   logic       rtErr8;

   int checks   = 0;
   int failures = 0;

   logic [3:0] grayTable [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
   logic [3:0] prevG;

   binary_to_gray_conv #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .b         (b4),
      .in_valid  (inValid4),
      .g         (g4),
      .out_valid (outValid4),
      .rt_err    (rtErr4)
   );

   binary_to_gray_conv #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .b         (b8),
      .in_valid  (inValid8),
      .g         (g8),
      .out_valid (outValid8),
      .rt_err    (rtErr8)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value against its expectation and tallies it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives the 4-bit port, then waits for the edge and settles 1 unit after it.
   task automatic applyStimulus(input logic valid, input logic [3:0] value);
      inValid4 = valid;
      b4       = value;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b0;
      b4       = 4'h0;
      inValid4 = 1'b0;
      b8       = 8'h00;
      inValid8 = 1'b0;

      // Reset asserted with a word offered: nothing may be captured.
      #2;
      inValid4 = 1'b1;
      b4       = 4'hF;
      rst      = 1'b1;
      #1;
      checkOutput("reset_async_g", 32'(g4), 32'h0);
      checkOutput("reset_async_valid", 32'(outValid4), 32'h0);
      checkOutput("reset_async_err", 32'(rtErr4), 32'h0);
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 4'hF);
         checkOutput("reset_hold_g", 32'(g4), 32'h0);
         checkOutput("reset_hold_valid", 32'(outValid4), 32'h0);
         checkOutput("reset_hold_err", 32'(rtErr4), 32'h0);
      end
      rst = 1'b0;

      // Full sweep 0..15 back to back, then wrap to 0.
      prevG = 4'h0;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 4'(i % 16));
         checkOutput($sformatf("sweep_g_%0d", i), 32'(g4), 32'(grayTable[i % 16]));
         checkOutput($sformatf("sweep_valid_%0d", i), 32'(outValid4), 32'h1);
         checkOutput($sformatf("sweep_err_%0d", i), 32'(rtErr4), 32'h0);
         checkOutput($sformatf("sweep_decode_%0d", i), gray2bin(32'(g4), 4), 32'(i % 16));
         if (i > 0) begin
            checkOutput($sformatf("sweep_onebit_%0d", i), 32'($countones(g4 ^ prevG)), 32'h1);
         end
         prevG = g4;
      end

      // Hold: g keeps the code for 9 while in_valid is low, even with X on b.
      applyStimulus(1'b1, 4'd9);
      checkOutput("hold_load_g", 32'(g4), 32'hD);
      applyStimulus(1'b0, 4'd3);
      checkOutput("hold_b3_g", 32'(g4), 32'hD);
      checkOutput("hold_b3_valid", 32'(outValid4), 32'h0);
      applyStimulus(1'b0, 4'bxxxx);
      checkOutput("hold_bx_g", 32'(g4), 32'hD);
      checkOutput("hold_bx_valid", 32'(outValid4), 32'h0);
      checkOutput("hold_bx_err", 32'(rtErr4), 32'h0);

      // Mid-stream reset between edges discards the word in flight.
      applyStimulus(1'b1, 4'd6);
      checkOutput("mid_pre_g", 32'(g4), 32'h5);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid_async_g", 32'(g4), 32'h0);
      checkOutput("mid_async_valid", 32'(outValid4), 32'h0);
      rst = 1'b0;
      applyStimulus(1'b1, 4'd7);
      checkOutput("mid_resume_g", 32'(g4), 32'h4);
      checkOutput("mid_resume_valid", 32'(outValid4), 32'h1);
      applyStimulus(1'b0, 4'd0);
      checkOutput("mid_resume_err", 32'(rtErr4), 32'h0);

      // Width scaling on the 8-bit instance, back to back.
      inValid8 = 1'b1;
      b8       = 8'hFF;
      @(posedge clk);
      #1;
      checkOutput("w8_ff_g", 32'(g8), 32'h80);
      checkOutput("w8_ff_valid", 32'(outValid8), 32'h1);
      b8 = 8'hA5;
      @(posedge clk);
      #1;
      checkOutput("w8_a5_g", 32'(g8), 32'hF7);
      checkOutput("w8_a5_err_prev", 32'(rtErr8), 32'h0);
      inValid8 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("w8_hold_g", 32'(g8), 32'hF7);
      checkOutput("w8_drop_valid", 32'(outValid8), 32'h0);
      checkOutput("w8_err", 32'(rtErr8), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
